// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data-RAM arbiter: FSM state encoding and
// starvation-counter sizing.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // Bits needed to count from 0 up to and including limit.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/data_mem_arb_pick.sv
// Combinational grant selection: port 0 has fixed priority unless port 1 has
// waited through STARVE_LIMIT consecutive port-0 wins.
module data_mem_arb_pick #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             req0,
  input  logic             req1,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_valid,
  output logic             grant_sel
);

  logic at_limit;

  assign at_limit    = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_valid = req0 | req1;
  // Port 1 wins when starving, or when port 0 is not asking at all.
  assign grant_sel   = (req1 & at_limit) | ~req0;

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM. Each access
// takes IDLE -> ACCESS -> RESP; byte addresses are converted to word addresses.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wen0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              wen1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  localparam int CNT_W = cnt_width(STARVE_LIMIT);

  arb_state_e        state_reg;
  logic              owner_reg;
  logic [CNT_W-1:0]  starve_cnt_reg;
  logic              grant_valid;
  logic              grant_sel;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_wen;
  logic [DATA_W-1:0] sel_wdata;
  logic              unused_addr_lsbs;

  data_mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .req0        (req0),
    .req1        (req1),
    .starve_cnt  (starve_cnt_reg),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  assign sel_addr  = grant_sel ? addr1  : addr0;
  assign sel_wen   = grant_sel ? wen1   : wen0;
  assign sel_wdata = grant_sel ? wdata1 : wdata0;

  // The RAM is word-addressed; byte lane bits are dropped.
  assign unused_addr_lsbs = ^sel_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= 1'b0;
      starve_cnt_reg <= '0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_din        <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner_reg <= grant_sel;
            ram_addr  <= {2'b00, sel_addr[ADDR_W-1:2]};
            ram_we    <= sel_wen;
            ram_din   <= sel_wdata;
            state_reg <= ARB_ACCESS;
            if (grant_sel)
              starve_cnt_reg <= '0;
            else if (req1 && starve_cnt_reg != CNT_W'(STARVE_LIMIT))
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
          end
        end
        ARB_ACCESS: begin
          // RAM samples the write at this edge; drop we so it lasts one cycle.
          ram_we    <= 1'b0;
          state_reg <= ARB_RESP;
        end
        ARB_RESP: begin
          state_reg <= ARB_IDLE;
        end
        default: begin
          ram_we    <= 1'b0;
          state_reg <= ARB_IDLE;
        end
      endcase
    end
  end

  // Responses decode straight from registered state so reset clears them at once.
  assign ack0   = (state_reg == ARB_RESP) && !owner_reg;
  assign ack1   = (state_reg == ARB_RESP) &&  owner_reg;
  assign rdata0 = ack0 ? ram_dout : '0;
  assign rdata1 = ack1 ? ram_dout : '0;
  assign busy   = (state_reg != ARB_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 1-cycle synchronous RAM model.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, wen0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        req1 = 1'b0, wen1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ack0, ack1, ram_we, busy;
  logic [31:0] rdata0, rdata1, ram_addr, ram_din;
  logic [31:0] ram_dout;
  logic        mem_init = 1'b1;
  logic [31:0] mem [0:63];
  int          we_cycles = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .wen0     (wen0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .ack0     (ack0),
    .rdata0   (rdata0),
    .req1     (req1),
    .wen1     (wen1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .ack1     (ack1),
    .rdata1   (rdata1),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .busy     (busy)
  );

  // RAM model: word i preloads to A5A5_00ii except word 4.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 4) ? 32'h1234_5678 : {16'hA5A5, 16'(i)};
    end else if (ram_we) begin
      mem[ram_addr[5:0]] <= ram_din;
    end
    ram_dout <= mem[ram_addr[5:0]];
  end

  always @(negedge clk) if (ram_we) we_cycles++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          we_snap;
    logic        got;
    logic [9:0]  exp_order;
    logic [31:0] exp_rd;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    rst = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);

    // Port 0 read of 0x10
    req0 = 1'b1; wen0 = 1'b0; addr0 = 32'h10;
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_ram_addr", ram_addr, 32'h4);
    chk("t1_ram_we", ram_we, 0);
    chk("t1_ack0_early", ack0, 0);
    @(negedge clk);
    chk("t1_ack0", ack0, 1);
    chk("t1_rdata0", rdata0, 32'h1234_5678);
    chk("t1_ack1", ack1, 0);
    $display("txn p0 rd addr=0x%08h rdata=0x%08h", addr0, rdata0);
    req0 = 1'b0;
    @(negedge clk);
    chk("t1_idle", busy, 0);
    chk("t1_ack0_gone", ack0, 0);

    // Unaligned port 0 read of 0x13
    req0 = 1'b1; addr0 = 32'h13;
    @(negedge clk);
    chk("t5_ram_addr", ram_addr, 32'h4);
    @(negedge clk);
    chk("t5_ack0", ack0, 1);
    chk("t5_rdata0", rdata0, 32'h1234_5678);
    $display("txn p0 rd addr=0x%08h rdata=0x%08h", addr0, rdata0);
    req0 = 1'b0;
    @(negedge clk);

    // Port 1 write then port 0 read-back
    we_snap = we_cycles;
    req1 = 1'b1; wen1 = 1'b1; addr1 = 32'h8; wdata1 = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t2_ram_we", ram_we, 1);
    chk("t2_ram_addr", ram_addr, 32'h2);
    chk("t2_ram_din", ram_din, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_ack1", ack1, 1);
    chk("t2_ack0", ack0, 0);
    chk("t2_we_resp", ram_we, 0);
    $display("txn p1 wr addr=0x%08h wdata=0x%08h", addr1, wdata1);
    req1 = 1'b0; wen1 = 1'b0;
    @(negedge clk);
    chk("t2_idle", busy, 0);
    chk("t2_we_cycles", 32'(we_cycles - we_snap), 1);
    req0 = 1'b1; addr0 = 32'h8;
    repeat (2) @(negedge clk);
    chk("t2_rb_ack0", ack0, 1);
    chk("t2_rb_rdata0", rdata0, 32'hDEAD_BEEF);
    $display("txn p0 rd addr=0x%08h rdata=0x%08h", addr0, rdata0);
    req0 = 1'b0;
    @(negedge clk);

    // Request dropped during ACCESS
    req0 = 1'b1; addr0 = 32'h14;
    @(negedge clk);
    chk("t6_busy", busy, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("t6_ack0", ack0, 1);
    chk("t6_rdata0", rdata0, 32'hA5A5_0005);
    $display("txn p0 rd addr=0x%08h rdata=0x%08h (req dropped)", addr0, rdata0);
    @(negedge clk);
    chk("t6_idle", busy, 0);
    @(negedge clk);
    chk("t6_no_second", busy, 0);
    chk("t6_no_second_ack", ack0, 0);

    // Continuous contention: expect 0,0,0,0,1,0,0,0,0,1
    exp_order = 10'b10_0001_0000;
    req0 = 1'b1; addr0 = 32'h18; req1 = 1'b1; addr1 = 32'h1C;
    for (int g = 0; g < 10; g++) begin
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        @(negedge clk);
        if (ack0 || ack1) got = 1'b1;
      end
      chk($sformatf("t3_grant%0d_seen", g), got, 1);
      chk($sformatf("t3_grant%0d_sel", g), ack1, exp_order[g]);
      exp_rd = exp_order[g] ? 32'hA5A5_0007 : 32'hA5A5_0006;
      chk($sformatf("t3_grant%0d_rdata", g), ack1 ? rdata1 : rdata0, exp_rd);
      if (exp_order[g])
        chk($sformatf("t3_grant%0d_starve", g), 32'(dut.starve_cnt_reg), 0);
      $display("txn grant %0d to p%0d rdata=0x%08h", g, ack1, ack1 ? rdata1 : rdata0);
      if (g == 9) begin
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("t3_idle", busy, 0);

    // Reset during ACCESS of a port 1 write
    req1 = 1'b1; wen1 = 1'b1; addr1 = 32'h24; wdata1 = 32'hCAFE_F00D;
    @(negedge clk);
    chk("t4_we_before", ram_we, 1);
    #2 rst = 1'b1;
    #1;
    chk("t4_we_async", ram_we, 0);
    chk("t4_busy_async", busy, 0);
    chk("t4_ack1_async", ack1, 0);
    req1 = 1'b0; wen1 = 1'b0;
    @(negedge clk);
    chk("t4_ack1_none", ack1, 0);
    chk("t4_mem_kept", mem[9], 32'hA5A5_0009);
    $display("txn p1 wr addr=0x%08h aborted by reset", addr1);
    rst = 1'b0;
    @(negedge clk);
    req0 = 1'b1; wen0 = 1'b0; addr0 = 32'h24;
    repeat (2) @(negedge clk);
    chk("t4_after_ack0", ack0, 1);
    chk("t4_after_rdata0", rdata0, 32'hA5A5_0009);
    $display("txn p0 rd addr=0x%08h rdata=0x%08h", addr0, rdata0);
    req0 = 1'b0;
    @(negedge clk);
    chk("t4_after_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
